// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the MIPS run-control sequencer and its helpers.
//   - ctrl_state_t : run-control FSM states. The numeric values are visible
//                    to the debug host through state_o.
//   - CMD_*        : cmd_op encodings used on the host command channel.
//   - FLUSH_CYCLES_DEF : default restart flush length, one cycle per stage.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FLUSH = 3'd4
    } ctrl_state_t;

    localparam logic [1:0] CMD_RUN     = 2'd0;
    localparam logic [1:0] CMD_STEP    = 2'd1;
    localparam logic [1:0] CMD_HALT    = 2'd2;
    localparam logic [1:0] CMD_RESTART = 2'd3;

    localparam int FLUSH_CYCLES_DEF = 5;

endpackage

// File: rtl/mips_sat_counter.sv
// -----------------------------------------------------------------------------
// mips_sat_counter
// CNT_W-bit up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (count -> 0)
//   clr   : synchronous clear, takes priority over inc
//   inc   : add one this cycle (ignored once saturated)
//   count : current value
// -----------------------------------------------------------------------------
module mips_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/mips_exec_controller.sv
// -----------------------------------------------------------------------------
// mips_exec_controller
// Run-control sequencer for the 5-stage MIPS pipeline. Decides each cycle
// whether the pipeline advances or is flushed, takes RUN/STEP/HALT/RESTART
// from the debug host, detects a retired HALT and counts executed cycles.
//
// Optional feature macro: MIPS_EXEC_BREAKPOINT_EN
//   Adds a PC breakpoint (bp_valid, bp_pc, if_pc, bp_hit). A match while
//   running drops back to IDLE after the matching cycle; STEP ignores it.
//
// Ports:
//   ClockIn     : system clock, rising edge
//   Reset       : synchronous active-high reset
//   cmd_valid   : host command present
//   cmd_op      : 0 RUN, 1 STEP, 2 HALT, 3 RESTART
//   cmd_ready   : command can be accepted this cycle (decoded from state)
//   wb_halt     : HALT instruction valid in MEM/WB
//   pipe_en     : pipeline advance enable
//   pipe_flush  : synchronous clear of PC and pipeline registers
//   state_o     : FSM state encoding for the host
//   done        : program retired a HALT
//   cycle_count : cycles with pipe_en=1 since last RESTART/Reset (saturating)
//   bp_valid, bp_pc, if_pc, bp_hit : breakpoint interface (macro only)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE  0  | pipeline frozen, waiting for a host command
// RUN   1  | free running until HALT retires, HALT command or breakpoint
// STEP  2  | exactly one advance cycle, then back to IDLE (or DONE)
// DONE  3  | HALT retired; only RESTART leaves
// FLUSH 4  | pipe_flush held FLUSH_CYCLES cycles, then IDLE
// -----------------------------------------------------------------------------
module mips_exec_controller
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
`ifdef MIPS_EXEC_BREAKPOINT_EN
    ,
    parameter int PC_W         = 32
`endif
) (
    input  logic             ClockIn,
    input  logic             Reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    input  logic             wb_halt,
    output logic             pipe_en,
    output logic             pipe_flush,
    output logic [2:0]       state_o,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count
`ifdef MIPS_EXEC_BREAKPOINT_EN
    ,
    input  logic             bp_valid,
    input  logic [PC_W-1:0]  bp_pc,
    input  logic [PC_W-1:0]  if_pc,
    output logic             bp_hit
`endif
);

    // Counter wide enough to hold FLUSH_CYCLES-1 (at least one bit).
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    ctrl_state_t     state;
    ctrl_state_t     next_state;
    logic [FC_W-1:0] flush_cnt;
    logic            cmd_fire;
    logic            flush_entry;
    logic            bp_go;

    assign cmd_ready = (state == ST_IDLE) || (state == ST_RUN) || (state == ST_DONE);
    assign cmd_fire  = cmd_valid && cmd_ready;

`ifdef MIPS_EXEC_BREAKPOINT_EN
    assign bp_go = bp_valid && (if_pc == bp_pc);
`else
    assign bp_go = 1'b0;
`endif

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pipe_en    = 1'b0;
        pipe_flush = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        CMD_RUN:     next_state = ST_RUN;
                        CMD_STEP:    next_state = ST_STEP;
                        CMD_RESTART: next_state = ST_FLUSH;
                        default:     next_state = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                pipe_en = 1'b1;
                // Retired HALT beats breakpoint, which beats host commands.
                if (wb_halt) begin
                    next_state = ST_DONE;
                end else if (bp_go) begin
                    next_state = ST_IDLE;
                end else if (cmd_fire && (cmd_op == CMD_HALT)) begin
                    next_state = ST_IDLE;
                end else if (cmd_fire && (cmd_op == CMD_RESTART)) begin
                    next_state = ST_FLUSH;
                end
            end
            ST_STEP: begin
                pipe_en    = 1'b1;
                next_state = wb_halt ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (cmd_fire && (cmd_op == CMD_RESTART)) begin
                    next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                pipe_flush = 1'b1;
                if (flush_cnt == '0) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign flush_entry = (state != ST_FLUSH) && (next_state == ST_FLUSH);

    // Loaded with FLUSH_CYCLES-1 on entry; terminal count zero ends FLUSH.
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            flush_cnt <= '0;
        end else if (flush_entry) begin
            flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
        end else if ((state == ST_FLUSH) && (flush_cnt != '0)) begin
            flush_cnt <= flush_cnt - FC_W'(1);
        end
    end

`ifdef MIPS_EXEC_BREAKPOINT_EN
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            bp_hit <= 1'b0;
        end else begin
            bp_hit <= (state == ST_RUN) && !wb_halt && bp_go;
        end
    end
`endif

    // The counter clears on FLUSH entry even if that edge would also count.
    mips_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_cnt (
        .clk   (ClockIn),
        .rst   (Reset),
        .clr   (flush_entry),
        .inc   (pipe_en),
        .count (cycle_count)
    );

    assign state_o = state;

endmodule

// File: tb/tb_mips_exec_controller.sv
module tb_mips_exec_controller;
    import mips_ctrl_pkg::*;

    logic        ClockIn = 1'b0;
    always #5 ClockIn = ~ClockIn;

    // Main DUT (default parameters)
    logic        Reset, cmd_valid, wb_halt;
    logic [1:0]  cmd_op;
    logic        cmd_ready, pipe_en, pipe_flush, done;
    logic [2:0]  state_o;
    logic [31:0] cycle_count;

    // Small DUT for saturation and single-cycle flush
    logic        s_rst, s_cv, s_wbh;
    logic [1:0]  s_op;
    logic        s_ready, s_en, s_flush, s_done;
    logic [2:0]  s_state;
    logic [2:0]  s_cnt;

`ifdef MIPS_EXEC_BREAKPOINT_EN
    logic        bp_valid, bp_hit, s_bp_hit;
    logic [31:0] bp_pc, if_pc;
`endif

    mips_exec_controller dut (
        .ClockIn     (ClockIn),
        .Reset       (Reset),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_ready   (cmd_ready),
        .wb_halt     (wb_halt),
        .pipe_en     (pipe_en),
        .pipe_flush  (pipe_flush),
        .state_o     (state_o),
        .done        (done),
        .cycle_count (cycle_count)
`ifdef MIPS_EXEC_BREAKPOINT_EN
        ,
        .bp_valid    (bp_valid),
        .bp_pc       (bp_pc),
        .if_pc       (if_pc),
        .bp_hit      (bp_hit)
`endif
    );

    mips_exec_controller #(.CNT_W(3), .FLUSH_CYCLES(1)) dut_s (
        .ClockIn     (ClockIn),
        .Reset       (s_rst),
        .cmd_valid   (s_cv),
        .cmd_op      (s_op),
        .cmd_ready   (s_ready),
        .wb_halt     (s_wbh),
        .pipe_en     (s_en),
        .pipe_flush  (s_flush),
        .state_o     (s_state),
        .done        (s_done),
        .cycle_count (s_cnt)
`ifdef MIPS_EXEC_BREAKPOINT_EN
        ,
        .bp_valid    (1'b0),
        .bp_pc       (32'd0),
        .if_pc       (32'd0),
        .bp_hit      (s_bp_hit)
`endif
    );

    typedef struct {
        logic        rst;
        logic        cv;
        logic [1:0]  op;
        logic        wbh;
        logic [2:0]  st;
        logic        en;
        logic        fl;
        logic        rdy;
        logic        dn;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic cv, input logic [1:0] op, input logic wbh,
                       input logic [2:0] st, input logic en, input logic fl, input logic rdy,
                       input logic dn, input logic [31:0] cnt);
        vec_t v;
        v.rst = r; v.cv = cv; v.op = op; v.wbh = wbh;
        v.st = st; v.en = en; v.fl = fl; v.rdy = rdy; v.dn = dn; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    // RESTART accepted now; expect FLUSH for 5 cycles then IDLE.
    task automatic add_restart();
        add(0, 1, CMD_RESTART, 0, 3'd4, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 0, CMD_RUN, 0, 3'd4, 0, 1, 0, 0, 0);
        add(0, 0, CMD_RUN, 0, 3'd0, 0, 0, 1, 0, 0);
    endtask

    task automatic tick();
        @(posedge ClockIn);
        #1;
    endtask

    initial begin
        Reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; wb_halt = 1'b0;
        s_rst = 1'b1; s_cv = 1'b0; s_op = 2'd0; s_wbh = 1'b0;
`ifdef MIPS_EXEC_BREAKPOINT_EN
        bp_valid = 1'b0; bp_pc = 32'h10; if_pc = 32'h0;
`endif

        // inputs applied before the edge, outputs expected after it
        add(1, 0, CMD_RUN, 0, 3'd0, 0, 0, 1, 0, 0);
        add(1, 0, CMD_RUN, 0, 3'd0, 0, 0, 1, 0, 0);
        add(0, 0, CMD_RUN, 0, 3'd0, 0, 0, 1, 0, 0);
        // RUN, HALT retires in the 7th run cycle
        add(0, 1, CMD_RUN, 0, 3'd1, 1, 0, 1, 0, 0);
        for (int i = 1; i <= 6; i++) add(0, 0, CMD_RUN, 0, 3'd1, 1, 0, 1, 0, i);
        add(0, 0, CMD_RUN, 1, 3'd3, 0, 0, 1, 1, 7);
        // DONE ignores RUN, HALT and wb_halt
        add(0, 1, CMD_RUN,  0, 3'd3, 0, 0, 1, 1, 7);
        add(0, 1, CMD_HALT, 0, 3'd3, 0, 0, 1, 1, 7);
        add(0, 0, CMD_RUN,  1, 3'd3, 0, 0, 1, 1, 7);
        // RESTART with RUN held during FLUSH (never accepted)
        add(0, 1, CMD_RESTART, 0, 3'd4, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, CMD_RUN, 0, 3'd4, 0, 1, 0, 0, 0);
        add(0, 1, CMD_RUN, 0, 3'd0, 0, 0, 1, 0, 0);
        add(0, 0, CMD_RUN, 0, 3'd0, 0, 0, 1, 0, 0);
        // STEP x3, second one held while cmd_ready=0
        add(0, 1, CMD_STEP, 0, 3'd2, 1, 0, 0, 0, 0);
        add(0, 1, CMD_STEP, 0, 3'd0, 0, 0, 1, 0, 1);
        add(0, 1, CMD_STEP, 0, 3'd2, 1, 0, 0, 0, 1);
        add(0, 0, CMD_STEP, 0, 3'd0, 0, 0, 1, 0, 2);
        add(0, 1, CMD_STEP, 0, 3'd2, 1, 0, 0, 0, 2);
        add(0, 0, CMD_STEP, 0, 3'd0, 0, 0, 1, 0, 3);
        // HALT and wb_halt have no effect in IDLE
        add(0, 1, CMD_HALT, 0, 3'd0, 0, 0, 1, 0, 3);
        add(0, 0, CMD_RUN,  1, 3'd0, 0, 0, 1, 0, 3);
        // STEP that retires HALT goes to DONE
        add(0, 1, CMD_STEP, 0, 3'd2, 1, 0, 0, 0, 3);
        add(0, 0, CMD_RUN,  1, 3'd3, 0, 0, 1, 1, 4);
        add_restart();
        // HALT command and wb_halt together: DONE wins
        add(0, 1, CMD_RUN,  0, 3'd1, 1, 0, 1, 0, 0);
        add(0, 1, CMD_HALT, 1, 3'd3, 0, 0, 1, 1, 1);
        add_restart();
        // RUN, STEP ignored, HALT -> IDLE, RUN resumes count, RESTART from RUN
        add(0, 1, CMD_RUN,  0, 3'd1, 1, 0, 1, 0, 0);
        add(0, 1, CMD_STEP, 0, 3'd1, 1, 0, 1, 0, 1);
        add(0, 1, CMD_HALT, 0, 3'd0, 0, 0, 1, 0, 2);
        add(0, 1, CMD_RUN,  0, 3'd1, 1, 0, 1, 0, 2);
        add_restart();
        // Reset mid-RUN at cycle_count=12
        add(0, 1, CMD_RUN, 0, 3'd1, 1, 0, 1, 0, 0);
        for (int i = 1; i <= 12; i++) add(0, 0, CMD_RUN, 0, 3'd1, 1, 0, 1, 0, i);
        add(1, 1, CMD_RUN, 0, 3'd0, 0, 0, 1, 0, 0);

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            Reset = vecs[i].rst; cmd_valid = vecs[i].cv; cmd_op = vecs[i].op; wb_halt = vecs[i].wbh;
            tick();
            chk($sformatf("v%0d state", i), 32'(state_o), 32'(vecs[i].st));
            chk($sformatf("v%0d pipe_en", i), 32'(pipe_en), 32'(vecs[i].en));
            chk($sformatf("v%0d pipe_flush", i), 32'(pipe_flush), 32'(vecs[i].fl));
            chk($sformatf("v%0d cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].dn));
            chk($sformatf("v%0d cycle_count", i), cycle_count, vecs[i].cnt);
        end
        Reset = 1'b0; cmd_valid = 1'b0; wb_halt = 1'b0;

        // Saturation on a 3-bit counter, then a single-cycle flush
        tick();
        s_rst = 1'b0; s_cv = 1'b1; s_op = CMD_RUN;
        tick();
        s_cv = 1'b0;
        repeat (10) tick();
        chk("sat state", 32'(s_state), 32'd1);
        chk("sat count", 32'(s_cnt), 32'd7);
        s_cv = 1'b1; s_op = CMD_RESTART;
        tick();
        s_cv = 1'b0;
        chk("short flush state", 32'(s_state), 32'd4);
        chk("short flush pipe_flush", 32'(s_flush), 32'd1);
        chk("short flush count", 32'(s_cnt), 32'd0);
        tick();
        chk("short flush exit state", 32'(s_state), 32'd0);
        chk("short flush exit pipe_flush", 32'(s_flush), 32'd0);

`ifdef MIPS_EXEC_BREAKPOINT_EN
        chk("bp_hit after reset", 32'(bp_hit), 32'd0);
        bp_valid = 1'b1; bp_pc = 32'h10; if_pc = 32'h0;
        cmd_valid = 1'b1; cmd_op = CMD_RUN;
        tick();
        cmd_valid = 1'b0;
        if_pc = 32'h4;  tick();
        chk("bp pc4 bp_hit", 32'(bp_hit), 32'd0);
        if_pc = 32'h8;  tick();
        chk("bp pc8 state", 32'(state_o), 32'd1);
        if_pc = 32'h10;
        chk("bp match cycle pipe_en", 32'(pipe_en), 32'd1);
        tick();
        chk("bp hit pulse", 32'(bp_hit), 32'd1);
        chk("bp hit state", 32'(state_o), 32'd0);
        chk("bp hit count", cycle_count, 32'd3);
        tick();
        chk("bp hit cleared", 32'(bp_hit), 32'd0);
        cmd_valid = 1'b1; cmd_op = CMD_STEP;
        tick();
        cmd_valid = 1'b0;
        chk("bp step state", 32'(state_o), 32'd2);
        tick();
        chk("bp step no hit", 32'(bp_hit), 32'd0);
        chk("bp step back to idle", 32'(state_o), 32'd0);
        chk("bp step count", cycle_count, 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_exec_controller.md
Name: mips_exec_controller

Overview:
- Run-control sequencer for the 5-stage MIPS pipeline. Decides each cycle whether the pipeline advances (global enable to PC, IF/ID, ID/EX, EX/MEM, MEM/WB) or is flushed.
- Accepts RUN / STEP / HALT / RESTART commands from the debug host over a valid/ready handshake.
- Detects program end when a HALT instruction retires in WB.
- Counts executed cycles for the host.

Parameters:
- CNT_W, 32, width of cycle counter.
- FLUSH_CYCLES, 5, number of cycles pipe_flush is held during RESTART (≥1; one per pipeline stage).
- PC_W, 32, PC width (used only with BREAKPOINT_EN).

Ports:
- ClockIn  in  1  single system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command present.
- cmd_op  in  2  command: 0 RUN, 1 STEP, 2 HALT, 3 RESTART.
- cmd_ready  out  1  controller can accept a command this cycle.
- wb_halt  in  1  HALT instruction is valid in MEM/WB this cycle.
- pipe_en  out  1  pipeline advance enable (AND'd with hazard-stall logic downstream).
- pipe_flush  out  1  synchronous clear of PC and all pipeline registers.
- state_o  out  3  current FSM state encoding, for the debug host.
- done  out  1  level; program retired a HALT.
- cycle_count  out  CNT_W  cycles with pipe_en=1 since last RESTART/Reset.

Behaviour:
- Reset (sync, any state, mid-operation included), next edge gives:
  - state=IDLE, pipe_en=0, pipe_flush=0, done=0, cycle_count=0.
  - Internal flush counter is cleared.
- Outputs:
  - pipe_en, pipe_flush and done are Moore outputs decoded from state.
  - cmd_ready is combinational from state.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready at a rising edge. One command per accept.
  - Non-accepted commands are held by the host; the controller stores nothing.
- States (state_o encoding): IDLE=0, RUN=1, STEP=2, DONE=3, FLUSH=4.
- IDLE: pipe_en=0; cmd_ready=1.
  - RUN → RUN.
  - STEP → STEP.
  - RESTART → FLUSH.
  - HALT accepted, no effect.
- RUN: pipe_en=1; cmd_ready=1; cycle_count+1 per cycle.
  - wb_halt=1 → DONE; the HALT cycle itself is counted.
  - HALT cmd → IDLE.
  - RESTART → FLUSH.
  - RUN/STEP accepted, ignored.
  - wb_halt and HALT cmd in the same cycle: DONE wins.
- STEP: exactly one cycle with pipe_en=1; cmd_ready=0; cycle_count+1.
  - Next state is IDLE, or DONE if wb_halt=1 in that cycle.
- DONE: pipe_en=0; done=1; cmd_ready=1.
  - RESTART → FLUSH.
  - All other commands accepted, ignored.
- FLUSH: pipe_flush=1, pipe_en=0, cmd_ready=0 for exactly FLUSH_CYCLES cycles.
  - cycle_count and done are cleared on entry.
  - → IDLE.
- Latency: an accepted command affects pipe_en on the cycle after acceptance.
- cycle_count saturates at all-ones; it does not wrap.
- wb_halt is ignored outside RUN and STEP.

Optional Feature:
- Macro: MIPS_EXEC_BREAKPOINT_EN.
- Defined:
  - Adds ports bp_valid (in, 1), bp_pc (in, PC_W), if_pc (in, PC_W), bp_hit (out, 1).
  - In RUN, when bp_valid && if_pc==bp_pc: next state is IDLE and bp_hit pulses for one cycle.
  - The matching cycle still has pipe_en=1.
  - wb_halt has priority over the breakpoint.
  - A STEP never triggers the breakpoint, so the host can step past it.
  - bp_hit resets to 0.
- Undefined: none of these ports exist; behaviour is as above.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - the state enum;
  - the cmd_op encodings (CMD_RUN, CMD_STEP, CMD_HALT, CMD_RESTART);
  - the FLUSH_CYCLES default.
- One sub-module: mips_sat_counter (CNT_W-bit saturating counter with clear and increment). It is reused by the debug unit's other counters.

Test Plan:
- Reset held 2 cycles, then released → state_o=0, pipe_en=0, cycle_count=0, cmd_ready=1.
- RUN accepted at cycle t; wb_halt=1 at t+7 → pipe_en=1 from t+1 to t+7; state DONE at t+8; done=1; cycle_count=7.
- STEP ×3, each issued after cmd_ready returns → three single-cycle pipe_en pulses; cmd_ready=0 during each STEP cycle; cycle_count=3.
- RUN, then HALT and wb_halt=1 in the same cycle → DONE (not IDLE); done=1.
- From DONE, RESTART with FLUSH_CYCLES=5 → pipe_flush=1 for exactly 5 cycles; cmd_valid during FLUSH not accepted; then IDLE, cycle_count=0, done=0.
- Reset asserted mid-RUN (cycle_count=12) → next edge: IDLE, pipe_en=0, cycle_count=0. With MIPS_EXEC_BREAKPOINT_EN: bp_pc=0x10, if_pc reaches 0x10 in RUN → single-cycle bp_hit, then IDLE.
